// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared modes, FSM/direction encodings and initial patterns for the LED sequencer
package led_seq_pkg;

  // Pattern modes as presented on the mode input
  localparam logic [1:0] MODE_BLINK  = 2'd0;
  localparam logic [1:0] MODE_BOUNCE = 2'd1;
  localparam logic [1:0] MODE_COUNT  = 2'd2;
  localparam logic [1:0] MODE_FILL   = 2'd3;

  // Widest pattern the INIT helper can describe
  localparam int MAX_WIDTH = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_t;

  // Starting pattern for a mode; callers truncate to their own width.
  // BLINK alternates bits with the MSB set, so width 8 gives 0xAA.
  function automatic logic [MAX_WIDTH-1:0] init_pattern(input logic [1:0] mode, input int width);
    logic [MAX_WIDTH-1:0] p;
    p = '0;
    if (mode == MODE_BLINK) begin
      for (int i = 0; i < MAX_WIDTH; i++) begin
        if ((i < width) && (((width - 1 - i) % 2) == 0)) begin
          p[i] = 1'b1;
        end
      end
    end else if (mode == MODE_BOUNCE) begin
      p[0] = 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/led_pwm_gate.sv
// rtl/led_pwm_gate.sv - free-running PWM counter that gates the pattern onto the LEDs
module led_pwm_gate #(
  parameter int WIDTH    = 8,
  parameter int PWM_BITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic [WIDTH-1:0]    pat,
  output logic [WIDTH-1:0]    leds
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                lit;

  // Full-scale brightness is forced on so all-ones means 100% rather than (2^N-1)/2^N
  assign lit = (brightness == {PWM_BITS{1'b1}}) || (pwm_cnt < brightness);

  // Counter free-runs and is cleared only by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Registered masking, so leds trails pat by one cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      leds <= '0;
    end else begin
      leds <= lit ? pat : '0;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - step-driven LED pattern FSM with PWM brightness and wrap pulse
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PWM_BITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                step,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [WIDTH-1:0]    leds,
  output logic                wrap
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  state_t           state;
  dir_t             dir;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] pat;

  logic [WIDTH-1:0] init_pat;
  logic [WIDTH-1:0] blink_init;
  logic [WIDTH-1:0] adv_pat;
  dir_t             adv_dir;
  logic             adv_wrap;

  // Starting patterns: the one for the requested mode, and BLINK's for its wrap test
  always_comb begin
    init_pat   = WIDTH'(init_pattern(mode, WIDTH));
    blink_init = WIDTH'(init_pattern(MODE_BLINK, WIDTH));
  end

  // Next pattern, direction and wrap flag for an ordinary advance in the latched mode
  always_comb begin
    adv_pat  = pat;
    adv_dir  = dir;
    adv_wrap = 1'b0;
    case (mode_q)
      MODE_BLINK: begin
        adv_pat  = ~pat;
        adv_wrap = (~pat == blink_init);
      end
      MODE_BOUNCE: begin
        if (dir == LEFT) begin
          if (pat[WIDTH-1]) begin
            adv_pat = pat >> 1;
            adv_dir = RIGHT;
          end else begin
            adv_pat = pat << 1;
          end
        end else begin
          adv_pat = pat >> 1;
        end
        // Arriving back at bit 0 closes the cycle; this also covers WIDTH=2
        if (adv_pat == ONE) begin
          adv_dir  = LEFT;
          adv_wrap = 1'b1;
        end
      end
      MODE_COUNT: begin
        adv_pat  = pat + ONE;
        adv_wrap = (pat == ONES);
      end
      default: begin
        if (pat == ONES) begin
          adv_pat  = '0;
          adv_wrap = 1'b1;
        end else begin
          adv_pat = (pat << 1) | ONE;
        end
      end
    endcase
  end

  // Pattern FSM: first step loads, later steps advance or reload on a mode change
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      pat    <= '0;
      mode_q <= MODE_BLINK;
      dir    <= LEFT;
      wrap   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (step) begin
            mode_q <= mode;
            pat    <= init_pat;
            dir    <= LEFT;
            state  <= RUN;
          end
        end
        RUN: begin
          if (step) begin
            if (mode != mode_q) begin
              mode_q <= mode;
              pat    <= init_pat;
              dir    <= LEFT;
            end else begin
              pat  <= adv_pat;
              dir  <= adv_dir;
              wrap <= adv_wrap;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  led_pwm_gate #(
    .WIDTH   (WIDTH),
    .PWM_BITS(PWM_BITS)
  ) u_pwm_gate (
    .clock     (clock),
    .reset     (reset),
    .brightness(brightness),
    .pat       (pat),
    .leds      (leds)
  );

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - scoreboard bench for the LED pattern sequencer
module tb_led_pattern_sequencer;

  localparam int W  = 8;
  localparam int PB = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          step  = 1'b0;
  logic [1:0]    mode  = 2'd0;
  logic [PB-1:0] brightness = 4'hF;
  logic [W-1:0]  leds;
  logic          wrap;

  int total = 0;
  int bad = 0;
  int wrap_seen = 0;

  typedef struct packed {
    logic [W-1:0] leds;
    logic         wrap;
  } exp_t;

  exp_t sb[$];

  led_pattern_sequencer #(
    .WIDTH(W),
    .PWM_BITS(PB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .step(step),
    .mode(mode),
    .brightness(brightness),
    .leds(leds),
    .wrap(wrap)
  );

  always #5 clock = ~clock;

  // Reference model: position within each mode's cycle
  bit           m_run  = 1'b0;
  logic [1:0]   m_mode = 2'd0;
  int           m_k    = 0;
  logic [W-1:0] m_pat  = '0;
  int           m_t    = 0;

  function automatic int period(input logic [1:0] md);
    case (md)
      2'd0:    return 2;
      2'd1:    return 2 * (W - 1);
      2'd2:    return 1 << W;
      default: return W + 1;
    endcase
  endfunction

  function automatic logic [W-1:0] pattern(input logic [1:0] md, input int k);
    case (md)
      2'd0:    return (k == 0) ? 8'hAA : 8'h55;
      2'd1:    return W'(1 << ((k < W) ? k : 2 * (W - 1) - k));
      2'd2:    return W'(k);
      default: return W'((1 << k) - 1);
    endcase
  endfunction

  // Model step at each rising edge; expected post-edge outputs go to the scoreboard
  always @(posedge clock) begin
    exp_t e;
    e.leds = (!reset && ((brightness == 4'hF) || (m_t < int'(brightness)))) ? m_pat : '0;
    e.wrap = 1'b0;
    if (reset) begin
      m_run = 1'b0; m_mode = 2'd0; m_k = 0; m_pat = '0; m_t = 0;
    end else begin
      m_t = (m_t + 1) % 16;
      if (step) begin
        if (!m_run || mode != m_mode) begin
          m_run = 1'b1; m_mode = mode; m_k = 0;
        end else begin
          m_k = (m_k + 1) % period(m_mode);
          e.wrap = (m_k == 0);
        end
        m_pat = pattern(m_mode, m_k);
      end
    end
    sb.push_back(e);
  end

  // Monitor: compare DUT outputs against the oldest expectation
  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (leds !== e.leds || wrap !== e.wrap) begin
        bad++;
        $display("FAIL scoreboard t=%0t leds=%h wrap=%b required leds=%h wrap=%b",
                 $time, leds, wrap, e.leds, e.wrap);
      end
      if (wrap === 1'b1) wrap_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic step_once();
    step = 1'b1;
    tick(1);
    step = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic count_leds(input logic [W-1:0] val, output int n);
    n = 0;
    repeat (16) begin
      @(negedge clock);
      if (leds === val) n++;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    int w0;
    int n;
    tick(3);

    // Idle after reset: no output, no wrap
    reset = 1'b0; mode = 2'd1; brightness = 4'hF;
    w0 = wrap_seen;
    n = 0;
    repeat (50) begin
      @(negedge clock);
      if (leds !== 8'h00) n++;
    end
    tick(1);
    check("idle_leds_zero", n, 0);
    check("idle_no_wrap", wrap_seen - w0, 0);

    // BOUNCE: 15 spaced steps, one wrap on the return to 0x01
    w0 = wrap_seen;
    repeat (15) begin
      step_once();
      tick(3);
    end
    tick(2);
    check("bounce_wrap_count", wrap_seen - w0, 1);

    // COUNT: 257 back-to-back steps, one wrap on FF->00
    w0 = wrap_seen;
    mode = 2'd2;
    step = 1'b1;
    tick(257);
    step = 1'b0;
    tick(2);
    check("count_wrap_count", wrap_seen - w0, 1);

    // Mode change without step is ignored, step reloads FILL
    reset = 1'b1; tick(1); reset = 1'b0;
    mode = 2'd1;
    w0 = wrap_seen;
    repeat (4) step_once();
    mode = 2'd3;
    tick(10);
    repeat (3) step_once();
    tick(2);
    check("fill_reload_no_wrap", wrap_seen - w0, 0);
    @(negedge clock);
    check("fill_after_reload", leds, 8'h03);
    tick(1);

    // PWM duty in BLINK at 0xAA
    reset = 1'b1; tick(1); reset = 1'b0;
    mode = 2'd0;
    step_once();
    brightness = 4'd4;
    tick(3);
    count_leds(8'hAA, n);
    check("duty4_on", n, 4);
    count_leds(8'h00, n);
    check("duty4_off", n, 12);
    brightness = 4'd0;
    tick(2);
    count_leds(8'hAA, n);
    check("duty0_on", n, 0);
    brightness = 4'hF;
    tick(2);
    count_leds(8'hAA, n);
    check("dutyF_on", n, 16);

    // Reset wins over a simultaneous step at pat 0x55
    step_once();
    tick(2);
    reset = 1'b1; step = 1'b1;
    tick(1);
    reset = 1'b0; step = 1'b0;
    @(negedge clock);
    check("reset_step_leds", leds, 8'h00);
    check("reset_step_wrap", wrap, 0);
    tick(1);
    step_once();
    tick(1);
    @(negedge clock);
    check("reload_after_reset", leds, 8'hAA);
    tick(1);

    // Randomized traffic against the model
    repeat (3000) begin
      step = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 99) == 0) brightness = 4'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    reset = 1'b0; step = 1'b0;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Downstream consumer of the pulser's one-cycle strobe.
- Replaces the fixed constant LED drive in top with a stepped pattern generator: each step strobe advances an 8-bit pattern according to a selected mode.
- Output is gated by a PWM brightness stage before driving the board LEDs.
- Also emits a one-cycle wrap pulse when a pattern completes its cycle, for chaining or debug.

Parameters:
- WIDTH, 8: number of LEDs / pattern bits (must be at least 2).
- PWM_BITS, 4: width of brightness input and PWM counter.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- step  input  1  advance strobe from pulser; every cycle high counts as one step (level, no edge detect).
- mode  input  2  pattern select: 0 BLINK, 1 BOUNCE, 2 COUNT, 3 FILL.
- brightness  input  PWM_BITS  duty select; 0 = off, all-ones = fully on.
- leds  output  WIDTH  registered, PWM-gated pattern.
- wrap  output  1  registered one-cycle pulse on pattern cycle completion.

Behaviour:
- One clock; reset is synchronous and active-high. Port names are clock and reset. Reset has priority over step.
- Reset values: leds=0, wrap=0, pat=0, mode_q=0, dir=LEFT, pwm_cnt=0, state=IDLE.
- Two-state FSM, IDLE and RUN.
  - IDLE: pat holds 0.
  - IDLE, step=1: mode_q<=mode, pat<=INIT(mode), go to RUN, wrap stays 0.
- INIT values: BLINK 0xAA, BOUNCE 0x01, COUNT 0x00, FILL 0x00. For WIDTH≠8, BLINK uses alternating bits with the MSB-side 1 set.
- RUN, step=1, mode==mode_q: advance pat as follows.
  - BLINK: pat <= ~pat. Sequence 0xAA, 0x55, 0xAA; wrap when next==INIT.
  - BOUNCE: dir LEFT shifts left; if pat[WIDTH-1]=1, next=pat>>1 and dir<=RIGHT. dir RIGHT shifts right; if next==0x01, dir<=LEFT. Sequence 01,02..80,40..02,01, period 2*(WIDTH-1) steps; wrap when next==0x01.
  - COUNT: pat+1, modulo 2^WIDTH; wrap on 0xFF→0x00.
  - FILL: pat==all-ones → 0x00 with wrap; otherwise pat <= (pat<<1)|1. Sequence 00,01,03..FF,00.
- RUN, step=1, mode!=mode_q: mode_q<=mode, pat<=INIT(mode), dir<=LEFT, no wrap. A reload never asserts wrap.
- Mode changes without a step are ignored; pat and mode_q hold.
- Timing of pat and wrap:
  - pat updates on the edge where step=1.
  - wrap is high for exactly the cycle after that edge, coincident with the new pat.
  - Back-to-back steps are legal; wrap may then be high on consecutive cycles.
- PWM:
  - pwm_cnt is free-running PWM_BITS wide, increments every cycle, wraps, and is cleared only by reset.
  - lit = (brightness==all-ones) | (pwm_cnt < brightness).
  - leds <= lit ? pat : 0, registered, so leds lags pat by 1 cycle.
- brightness is sampled every cycle with no synchronisation; it is assumed static or driven from the clock domain.
- Reset mid-RUN returns to IDLE. A step in the same cycle is discarded.

Decomposition:
- Package led_seq_pkg holds:
  - mode constants MODE_BLINK=0, MODE_BOUNCE=1, MODE_COUNT=2, MODE_FILL=3;
  - state encoding IDLE/RUN;
  - dir encoding LEFT/RIGHT;
  - INIT pattern function of (mode, WIDTH).
- Sub-module led_pwm_gate contains the pwm counter, compare, and registered masking. Inputs: clock, reset, brightness, pat. Output: leds.
- The pattern FSM stays in led_pattern_sequencer.

Test Plan:
- Reset, mode=1, brightness=F, no step for 50 cycles → leds=0x00, wrap=0 throughout, state IDLE.
- mode=1, brightness=F, 15 steps spaced 4 cycles → first step gives pat 0x01, then 02,04..80,40..02,01; leds follows 1 cycle later; wrap pulses once, on the 15th step (return to 0x01).
- mode=2, brightness=F, 257 steps → values 00..FF then 00; wrap asserted exactly once, on the FF→00 step; pat never skips.
- BOUNCE at pat=0x08; switch mode to 3 with no step for 10 cycles, then step, step, step → pat stays 0x08 until the first step, then 0x00, 0x01, 0x03; wrap never asserts.
- mode=0, pat=0xAA, brightness=4 → over any 16 consecutive cycles leds=0xAA for exactly 4 cycles and 0x00 for 12; brightness=0 → always 0x00; brightness=F → always 0xAA.
- In RUN with pat=0x55, assert reset and step in the same cycle → next cycle leds=0, wrap=0, IDLE; a following step loads INIT(mode).
